// File: rtl/rs232_rx.sv
// rs232_rx: serial byte receiver for a 16-tick-per-bit RS-232 link.
// Each clk edge is one tick. The receiver detects the start bit, samples
// mid-bit, shifts in 8 data bits LSB-first and checks one stop bit. Good
// bytes are presented under a ready/ack handshake, with framing-error and
// overrun flags.
//
// Ports:
//   clk          tick clock (16x baud), posedge
//   rst_n        asynchronous active-low reset
//   signal_in    serial line, idles high, asynchronous to clk
//   data_ack     consumer takes data_out while data_ready is high
//   data_out     last correctly framed byte
//   data_ready   data_out holds an unconsumed byte
//   frame_error  sticky: last completed frame had a low stop bit
//   overrun      an unconsumed byte was overwritten
//   busy         receiver is not idle
//
// state | meaning
// IDLE  | waiting for a high-to-low transition on the synced line
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling 8 data bits at cnt = 24 + 16*i
// STOP  | sampling the stop bit at cnt = 152, then updating outputs
module rs232_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_in,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] dout_d;
  logic       rdy_d, fe_d, ovr_d;

  logic       sync1_q, rx, rx_prev, fall_q;

  // Two-flop synchronizer, previous-value flop, and a registered fall pulse.
  // Registering the fall puts START entry three edges after the pin is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx      <= 1'b1;
      rx_prev <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= signal_in;
      rx      <= sync1_q;
      rx_prev <= rx;
      fall_q  <= rx_prev & ~rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      sh_q        <= 8'd0;
      data_out    <= 8'd0;
      data_ready  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      data_out    <= dout_d;
      data_ready  <= rdy_d;
      frame_error <= fe_d;
      overrun     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = data_out;
    rdy_d   = data_ready;
    fe_d    = frame_error;
    ovr_d   = overrun;

    if (data_ready && data_ack) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (fall_q) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd8) begin
          if (rx) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 8'd1;
        // cnt is always above 8 here, so low nibble 8 hits 24, 40, ... 136
        if (cnt_q[3:0] == 4'h8) begin
          sh_d = {rx, sh_q[7:1]};
          if (cnt_q == 8'd136) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd152) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          if (rx) begin
            dout_d = sh_q;
            rdy_d  = 1'b1;
            fe_d   = 1'b0;
            // An ack in this same cycle consumed the old byte: no overrun.
            ovr_d  = data_ready & ~data_ack;
          end else begin
            fe_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed table of frames with hand-computed expected outputs,
// plus hand-written glitch and mid-frame reset sequences.
module tb_rs232_rx;

  logic       clk;
  logic       rst_n;
  logic       signal_in;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  rs232_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal_in   (signal_in),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       ack_stop;
    logic       post_ack;
    logic [7:0] e_d;
    logic       e_r;
    logic       e_fe;
    logic       e_ov;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge. The first posedge after it is pin-fall cycle P.
  // Records busy/ready after edge P+155 and all outputs after edge P+156.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_stop,
                            output logic b155, output logic r155, output logic b156,
                            output logic [7:0] o_d, output logic o_r,
                            output logic o_fe, output logic o_ov);
    signal_in = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      signal_in = d[i];
      repeat (16) @(negedge clk);
    end
    signal_in = stop;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 11) begin
        b155 = busy;
        r155 = data_ready;
        data_ack = ack_stop;
      end
      if (j == 12) begin
        data_ack = 1'b0;
        b156 = busy;
        o_d  = data_out;
        o_r  = data_ready;
        o_fe = frame_error;
        o_ov = overrun;
      end
    end
    signal_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic       b155, r155, b156, o_r, o_fe, o_ov;
  logic [7:0] o_d;
  logic       prev_rdy;

  initial begin
    tbl[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h33, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'hC3, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{8'h96, 1'b1, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0, 1'b1};

    rst_n     = 1'b0;
    signal_in = 1'b1;
    data_ack  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset data_out", data_out, 8'h00);
    chk("reset ready", {7'd0, data_ready}, 8'd0);
    chk("reset busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle flags", {4'd0, data_ready, frame_error, overrun, busy}, 8'd0);

    // Glitch: 4 low ticks. START at P+3, back to IDLE at edge P+12.
    signal_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 3) signal_in = 1'b1;
      if (k == 4)  chk("glitch busy P+4", {7'd0, busy}, 8'd1);
      if (k == 11) chk("glitch busy P+11", {7'd0, busy}, 8'd1);
      if (k == 12) chk("glitch busy P+12", {7'd0, busy}, 8'd0);
    end
    chk("glitch flags", {4'd0, data_ready, frame_error, overrun, busy}, 8'd0);

    prev_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].ack_stop, b155, r155, b156, o_d, o_r, o_fe, o_ov);
      chk($sformatf("row%0d busy P+155", i), {7'd0, b155}, 8'd1);
      chk($sformatf("row%0d ready P+155", i), {7'd0, r155}, {7'd0, prev_rdy});
      chk($sformatf("row%0d busy P+156", i), {7'd0, b156}, 8'd0);
      chk($sformatf("row%0d data_out", i), o_d, tbl[i].e_d);
      chk($sformatf("row%0d ready", i), {7'd0, o_r}, {7'd0, tbl[i].e_r});
      chk($sformatf("row%0d frame_error", i), {7'd0, o_fe}, {7'd0, tbl[i].e_fe});
      chk($sformatf("row%0d overrun", i), {7'd0, o_ov}, {7'd0, tbl[i].e_ov});
      prev_rdy = tbl[i].e_r;
      if (tbl[i].post_ack) begin
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chk($sformatf("row%0d ack ready", i), {7'd0, data_ready}, 8'd0);
        chk($sformatf("row%0d ack overrun", i), {7'd0, overrun}, 8'd0);
        chk($sformatf("row%0d ack data_out", i), data_out, tbl[i].e_d);
        prev_rdy = 1'b0;
      end
      repeat (4) @(negedge clk);
    end

    // Reset during data bit 3 of 0xFF, with ready and overrun set beforehand.
    signal_in = 1'b0;
    repeat (16) @(negedge clk);
    signal_in = 1'b1;
    repeat (54) @(negedge clk);
    chk("midframe busy", {7'd0, busy}, 8'd1);
    chk("midframe ready", {6'd0, data_ready, overrun}, 8'd3);
    rst_n = 1'b0;
    #1;
    chk("async reset data_out", data_out, 8'h00);
    chk("async reset flags", {4'd0, data_ready, frame_error, overrun, busy}, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post reset flags", {4'd0, data_ready, frame_error, overrun, busy}, 8'd0);

    send_frame(8'h81, 1'b1, 1'b0, b155, r155, b156, o_d, o_r, o_fe, o_ov);
    chk("0x81 busy P+155", {7'd0, b155}, 8'd1);
    chk("0x81 ready P+155", {7'd0, r155}, 8'd0);
    chk("0x81 busy P+156", {7'd0, b156}, 8'd0);
    chk("0x81 data_out", o_d, 8'h81);
    chk("0x81 flags", {5'd0, o_r, o_fe, o_ov}, 8'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs232_rx.md
# rs232_rx

Serial byte receiver for the RS-232 link, the receive half paired with the 16-tick-per-bit transmitter. It runs on the same 16x oversampling clock: every `clk` edge is one tick, and one bit lasts 16 ticks. It detects the start bit, samples mid-bit, and shifts in 8 data bits LSB-first. After checking the stop bit, it presents the byte under a ready/ack handshake, with framing-error and overrun flags.

## Interface
- No parameters. Fixed values: 16 ticks/bit, 8 data bits, 1 stop bit, no parity.
- `clk`  in  1  tick clock (16x baud); all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `signal_in`  in  1  serial line; idles high; asynchronous to `clk`.
- `data_ack`  in  1  level; consumer takes `data_out` while `data_ready`=1.
- `data_out`  out  8  last correctly framed byte.
- `data_ready`  out  1  high while `data_out` holds an unconsumed byte.
- `frame_error`  out  1  sticky; the last completed frame had stop bit = 0.
- `overrun`  out  1  an unconsumed byte was overwritten by a newer one.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- **Synchronizer:** `signal_in` passes through 2 flops, both reset to 1. A third flop holds the previous synced value for edge detection. All logic below uses the synced line `rx`.
- **States:** IDLE, START, DATA, STOP. There is an 8-bit tick counter `cnt` and an 8-bit shift register `sh`.
- **IDLE:**
  - `cnt`=0.
  - On a falling edge of `rx` (previous=1, current=0), go to START with `cnt`=0 on the next cycle.
  - A line held low does not retrigger; a high-to-low transition is required.
- **START:**
  - `cnt` increments every cycle.
  - At `cnt`=8: if `rx`=0, go to DATA.
  - If `rx`=1 at `cnt`=8, it was a glitch: return to IDLE with no flag change.
- **DATA:**
  - At `cnt`=24+16·i (i=0..7), shift right: `sh` <= {`rx`, `sh[7:1]`}.
  - After the sample at `cnt`=136, go to STOP.
- **STOP:** at `cnt`=152, sample `rx`, then return to IDLE.
  - If `rx`=1: `data_out`<=`sh`, `data_ready`<=1, `frame_error`<=0, and `overrun`<=1 if `data_ready` was already 1 and not acked this cycle.
  - If `rx`=0: `frame_error`<=1; `data_out`, `data_ready` and `overrun` are unchanged.
- **Handshake:**
  - `data_ready`=1 and `data_ack`=1 in the same cycle: `data_ready`<=0 and `overrun`<=0 on the next edge.
  - `data_ack` while `data_ready`=0 is ignored.
- **Simultaneous ack and good stop in one cycle:** the new byte wins. `data_ready` stays 1 and `overrun`=0, because the old byte was consumed.
- **Reset mid-frame:** the frame is abandoned and no flags are set. Reset values:
  - `data_out`=0, `data_ready`=0, `frame_error`=0, `overrun`=0, `busy`=0.
  - state IDLE, `cnt`=0, `sh`=0.

## Timing
- Define pin-fall cycle P as the first edge at which `signal_in`=0 is registered. The edge is detected at P+2 and START is entered at P+3 (`cnt`=0).
- Sample points, counted from `cnt`=0: start bit at 8; data bit i at 24+16i; stop bit at 152. Each is 8 ticks into its bit, i.e. mid-bit.
- `data_ready` rises at P+3+153 = P+156 and stays high until ack. `data_out` is stable whenever `data_ready`=1.
- `busy` is high from P+3 through the STOP sample cycle and low the next cycle. Back-to-back frames are accepted as soon as IDLE sees the next falling edge.
- Tolerated drift: about ±7 ticks of accumulated error at the stop bit.
- Flags change only at the STOP sample or at an ack edge. Flag changes are registered, with zero combinational input-to-output paths.

## Test plan
- **Good frame:** idle high, then start bit and 0xA5 LSB-first at 16 ticks/bit, then stop=1.
  - `data_out`=0xA5 and `data_ready`=1 at P+156.
  - `frame_error`=0, `overrun`=0, `busy` low one cycle later.
- **Glitch:** `signal_in` low for 4 ticks, then high.
  - `busy` pulses, then returns to IDLE after `cnt`=8.
  - No `data_ready`; all flags stay 0.
- **Framing error:** byte 0x3C with stop bit 0.
  - `frame_error`=1, `data_ready`=0, `data_out` unchanged (0x00 after reset).
  - A following good 0x5A clears `frame_error` and presents 0x5A.
- **Overrun and ack:** send 0x11 then 0x22 without ack.
  - `data_out`=0x22, `overrun`=1.
  - Pulse `data_ack` for 1 cycle: `data_ready`=0 and `overrun`=0 on the next edge.
- **Ack collision:** assert `data_ack` exactly on the STOP sample cycle of a second byte 0x7E.
  - Result: `data_out`=0x7E, `data_ready`=1, `overrun`=0.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 of 0xFF.
  - All outputs go to 0 immediately.
  - After release, a new 0x81 frame is received correctly.
